// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID pipeline stage with a valid/ready handshake.
// A main entry plus one skid entry keep in_ready a pure register output
// while still sustaining one transfer per cycle. Flush invalidates both
// entries. Optional saturating stall/flush counters are compiled in when
// the macro IF_ID_PERF_CNT_EN is defined; otherwise they read constant 0.
module if_id_pipe #(
  parameter int INST_W = 19,
  parameter int PC_W   = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Main entry (what decode sees)
  logic              out_valid_q, out_valid_d;
  logic [INST_W-1:0] out_inst_q,  out_inst_d;
  logic [PC_W-1:0]   out_pc_q,    out_pc_d;

  // Skid entry (absorbs the one instruction in flight when decode stalls)
  logic              skid_valid_q, skid_valid_d;
  logic [INST_W-1:0] skid_inst_q,  skid_inst_d;
  logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;

  // Registered ready: mirrors the next-cycle emptiness of the skid entry
  logic              in_ready_q, in_ready_d;

  logic in_fire;
  logic main_free;

  // Handshake qualifiers; in_ready_q breaks any path from out_ready
  always_comb begin
    in_fire   = in_valid & in_ready_q;
    main_free = ~out_valid_q | out_ready;
  end

  // Next state of the two-entry buffer: flush beats normal operation
  always_comb begin
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      // Redirect: drop everything, including an instruction arriving now
      out_valid_d  = 1'b0;
      out_inst_d   = '0;
      out_pc_d     = '0;
      skid_valid_d = 1'b0;
      skid_inst_d  = '0;
      skid_pc_d    = '0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Older skid entry moves up first to keep strict FIFO order
        out_valid_d = 1'b1;
        out_inst_d  = skid_inst_q;
        out_pc_d    = skid_pc_q;
        if (in_fire) begin
          skid_valid_d = 1'b1;
          skid_inst_d  = in_inst;
          skid_pc_d    = in_pc;
        end else begin
          skid_valid_d = 1'b0;
          skid_inst_d  = '0;
          skid_pc_d    = '0;
        end
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_inst_d  = in_inst;
        out_pc_d    = in_pc;
      end else begin
        // Nothing to present; data is left as-is
        out_valid_d = 1'b0;
      end
    end else begin
      // Decode stalled: main holds, a newly accepted word parks in the skid
      if (in_fire) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = in_inst;
        skid_pc_d    = in_pc;
      end
    end

    in_ready_d = ~skid_valid_d;
  end

  // Buffer state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; flush cycles are not counted as stalls
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers: cleared only by reset, never by flush
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed self-checking bench for if_id_pipe. A second instance with a
// 2-bit counter width shares the stimulus and is used for saturation.
module tb_if_id_pipe;
  localparam int INST_W = 19;
  localparam int PC_W   = 12;
  localparam int CNT_W  = 16;
`ifdef IF_ID_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [INST_W-1:0] in_inst = '0;
  logic [PC_W-1:0]   in_pc = '0;
  logic              in_ready, out_valid;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  logic              s_in_ready, s_out_valid;
  logic [INST_W-1:0] s_out_inst;
  logic [PC_W-1:0]   s_out_pc;
  logic [1:0]        s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_id_pipe #(.INST_W(INST_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_pipe #(.INST_W(INST_W), .PC_W(PC_W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_inst(s_out_inst), .out_pc(s_out_pc),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_inst = INST_W'(110); in_pc = PC_W'(9); out_ready = 1'b1;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (out_inst !== '0) begin n_fail++; $display("FAIL reset_out_inst: got %0d want 0", out_inst); end
    n_checks++; if (out_pc !== '0) begin n_fail++; $display("FAIL reset_out_pc: got %0d want 0", out_pc); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    n_checks++; if (flush_cnt !== '0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt); end
    reset = 1'b1; in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: got %0b want 0", out_valid); end
    $display("reset: released, stage empty");
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_inst = INST_W'(k + 1); in_pc = PC_W'(72 + k);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %0b want 1", k, in_ready); end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_inst !== INST_W'(k + 1) || out_pc !== PC_W'(72 + k)) begin
        n_fail++;
        $display("FAIL stream_out[%0d]: got v=%0b inst=%0d pc=%0d want v=1 inst=%0d pc=%0d",
                 k, out_valid, out_inst, out_pc, k + 1, 72 + k);
      end
      $display("stream: inst %0d pc %0d", out_inst, out_pc);
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_stall();
    // Load 10 into the empty stage
    out_ready = 1'b1; in_valid = 1'b1; in_inst = INST_W'(10); in_pc = PC_W'(100);
    step();
    // Three stalled cycles; 11 is absorbed by the skid, 12 waits
    out_ready = 1'b0; in_inst = INST_W'(11); in_pc = PC_W'(101);
    step();
    n_checks++; if (out_inst !== INST_W'(10) || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold1: got v=%0b inst=%0d want v=1 inst=10", out_valid, out_inst); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_drop: got %0b want 0", in_ready); end
    in_inst = INST_W'(12); in_pc = PC_W'(102);
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if (out_inst !== INST_W'(10) || out_pc !== PC_W'(100)) begin n_fail++; $display("FAIL stall_hold[%0d]: got inst=%0d pc=%0d want inst=10 pc=100", k, out_inst, out_pc); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_low[%0d]: got %0b want 0", k, in_ready); end
    end
    n_checks++; if (stall_cnt !== CNT_W'(PERF ? 3 : 0)) begin n_fail++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, PERF ? 3 : 0); end
    $display("stall: inst 10 held for 3 cycles");
    // Release: skid (11) moves up, in_ready returns next cycle
    out_ready = 1'b1;
    step();
    n_checks++; if (out_inst !== INST_W'(11) || out_pc !== PC_W'(101)) begin n_fail++; $display("FAIL stall_release_11: got inst=%0d pc=%0d want inst=11 pc=101", out_inst, out_pc); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready_back: got %0b want 1", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_inst !== INST_W'(12) || out_pc !== PC_W'(102)) begin n_fail++; $display("FAIL stall_release_12: got v=%0b inst=%0d pc=%0d want v=1 inst=12 pc=102", out_valid, out_inst, out_pc); end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %0b want 0", out_valid); end
    n_checks++; if (stall_cnt !== CNT_W'(PERF ? 3 : 0)) begin n_fail++; $display("FAIL stall_cnt_after: got %0d want %0d", stall_cnt, PERF ? 3 : 0); end
    $display("stall: released, order 10,11,12");
  endtask

  task automatic test_flush();
    // Fill both entries with 20 and 21
    out_ready = 1'b0; in_valid = 1'b1; in_inst = INST_W'(20); in_pc = PC_W'(200);
    step();
    in_inst = INST_W'(21); in_pc = PC_W'(201);
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full: got in_ready=%0b want 0", in_ready); end
    flush = 1'b1; in_inst = INST_W'(22); in_pc = PC_W'(202);
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
    n_checks++; if (out_inst !== '0 || out_pc !== '0) begin n_fail++; $display("FAIL flush_data_clear: got inst=%0d pc=%0d want 0 0", out_inst, out_pc); end
    n_checks++; if (flush_cnt !== CNT_W'(PERF ? 1 : 0)) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", flush_cnt, PERF ? 1 : 0); end
    n_checks++; if (stall_cnt !== CNT_W'(PERF ? 4 : 0)) begin n_fail++; $display("FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, PERF ? 4 : 0); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_nothing_survives: got %0b want 0", out_valid); end
    $display("flush: 20,21,22 discarded");
    // Flush coinciding with out_fire of 30 and in_fire of 31
    in_valid = 1'b1; in_inst = INST_W'(30); in_pc = PC_W'(300);
    step();
    flush = 1'b1; in_inst = INST_W'(31); in_pc = PC_W'(301);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_fire_ready: got %0b want 1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_fire_drop: got %0b want 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_fire_late: got %0b want 0", out_valid); end
    n_checks++; if (flush_cnt !== CNT_W'(PERF ? 2 : 0)) begin n_fail++; $display("FAIL flush_cnt2: got %0d want %0d", flush_cnt, PERF ? 2 : 0); end
    $display("flush: 30 consumed, 31 dropped");
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = INST_W'(40); in_pc = PC_W'(400);
    step();
    in_inst = INST_W'(41); in_pc = PC_W'(401);
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rms_full: got in_ready=%0b want 0", in_ready); end
    reset = 1'b0; in_inst = INST_W'(42); in_pc = PC_W'(402);
    step();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rms_state: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready); end
    n_checks++; if (out_inst !== '0 || stall_cnt !== '0 || flush_cnt !== '0) begin n_fail++; $display("FAIL rms_clear: got inst=%0d stall=%0d flush=%0d want 0 0 0", out_inst, stall_cnt, flush_cnt); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rms_no_resurrect: got %0b want 0", out_valid); end
    $display("reset mid-stall: 40,41 lost");
  endtask

  task automatic test_saturation();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++; if (s_flush_cnt !== 2'(PERF ? ((k < 3) ? k : 3) : 0)) begin n_fail++; $display("FAIL sat_flush_cnt[%0d]: got %0d want %0d", k, s_flush_cnt, PERF ? ((k < 3) ? k : 3) : 0); end
      n_checks++; if (flush_cnt !== CNT_W'(PERF ? k : 0)) begin n_fail++; $display("FAIL wide_flush_cnt[%0d]: got %0d want %0d", k, flush_cnt, PERF ? k : 0); end
    end
    flush = 1'b0;
    step();
    n_checks++; if (s_flush_cnt !== 2'(PERF ? 3 : 0)) begin n_fail++; $display("FAIL sat_hold: got %0d want %0d", s_flush_cnt, PERF ? 3 : 0); end
    n_checks++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_state: got v=%0b rdy=%0b want v=0 rdy=1", s_out_valid, s_in_ready); end
    $display("saturation: 2-bit flush_cnt=%0d", s_flush_cnt);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Parametrised IF/ID pipeline stage between instruction fetch and decode, carrying instruction and PC with a valid/ready handshake instead of a free-running register. A two-entry (main + skid) buffer keeps `in_ready` registered while sustaining one transfer per cycle. Flush invalidates both entries. Optional saturating stall and flush counters support performance analysis.

## Interface
- `INST_W`, 19, instruction width in bits
- `PC_W`, 12, PC width in bits
- `CNT_W`, 16, width of each performance counter

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `flush`  in  1  invalidate stage contents (branch/jump redirect)
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage can accept; registered
- `in_inst`  in  INST_W  fetched instruction
- `in_pc`  in  PC_W  PC of fetched instruction
- `out_valid`  out  1  decode-side entry valid
- `out_ready`  in  1  decode accepts; low means stall
- `out_inst`  out  INST_W  instruction to decode
- `out_pc`  out  PC_W  PC to decode
- `stall_cnt`  out  CNT_W  cycles with `out_valid & ~out_ready`
- `flush_cnt`  out  CNT_W  cycles with `flush` high

## Operation
- State: main entry (`out_valid`, `out_inst`, `out_pc`) and skid entry (`skid_valid`, `skid_inst`, `skid_pc`).
- Handshakes:
  - `in_fire = in_valid & in_ready`
  - `out_fire = out_valid & out_ready`
  - `in_ready = ~skid_valid`, a register output with no combinational path from `out_ready`.
- Priority order per cycle:
  1. reset
  2. flush
  3. normal.
- Reset (`reset`=0 at edge):
  - all valids 0; all data registers 0; counters 0.
  - `in_ready` reads 1 after the reset edge.
  - Inputs are ignored while reset is held.
- Flush:
  - Both entries invalidated and their data cleared to 0.
  - Any `in_fire` in the same cycle is dropped.
  - Next cycle: `out_valid`=0, `in_ready`=1.
- Normal, main entry free (`~out_valid | out_fire`):
  - `skid_valid` → main loads skid. Skid then loads `in_inst`/`in_pc` if `in_fire`, else clears.
  - otherwise, `in_fire` → main loads input.
  - otherwise → `out_valid` goes 0 and data holds.
- Normal, main entry busy (`out_valid & ~out_ready`):
  - `in_fire` → skid loads input.
  - Main holds its data unchanged.
- Ordering: strict FIFO; skid always drains before any newer input.
- Occupancy is 0–2. At 2, `in_ready`=0 and `in_valid` is ignored; no overwrite is ever allowed.
- `out_inst`/`out_pc` are don't-care when `out_valid`=0, but hold or read 0 as specified above.

## Timing
- Latency: input accepted at edge N appears on outputs after edge N (visible in cycle N+1) when the stage is empty.
- Throughput: 1 instruction/cycle with `out_ready` held high; the skid is unused in that case.
- Stall: `out_ready` low for k cycles with a continuous source:
  - exactly one extra entry is absorbed;
  - `in_ready` drops one cycle after the skid fills;
  - `in_ready` returns one cycle after the skid drains.
- Simultaneous `flush` and `out_fire`: the fired entry is consumed by decode and nothing survives.
- Reset asserted mid-stall with a full skid: both entries are lost. No output glitch beyond the registered reset values.

## Configuration
- `IF_ID_PERF_CNT_EN` defined:
  - `stall_cnt` increments each cycle with `out_valid & ~out_ready & ~flush`.
  - `flush_cnt` increments each cycle with `flush`=1.
  - Both saturate at 2^CNT_W−1, are cleared by reset, and are not cleared by flush.
- Undefined: counter logic is not compiled; `stall_cnt` and `flush_cnt` are constant 0. Ports remain present.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `in_valid`=1, `in_inst`=110 → `out_valid`=0, `out_inst`=0, `out_pc`=0, `in_ready`=1, counters 0 after release.
- Streaming: `out_ready`=1, feed inst 1..5 with pc 72..76 back-to-back → outputs appear one cycle later, in order, one per cycle; `in_ready` stays 1.
- Stall:
  - `out_ready`=0 for 3 cycles while feeding inst 10, 11, 12 → 10 held on output, 11 in skid.
  - `in_ready`=0 after 11 is accepted; 12 is not accepted.
  - On release, output sequence is 10, 11, then 12 after re-accept.
  - With `IF_ID_PERF_CNT_EN`, `stall_cnt`=3.
- Flush with full skid: occupancy 2 (inst 20 and 21) plus `flush`=1 and `in_fire` of 22 → next cycle `out_valid`=0, `in_ready`=1, `out_inst`=0. 20, 21 and 22 never appear. `flush_cnt`=1 with macro.
- Saturation: `CNT_W`=2, `IF_ID_PERF_CNT_EN` defined, flush held 6 cycles → `flush_cnt`=3 and stays 3.
- Reset mid-stall: skid full, then `reset`=0 for one cycle → both entries gone, `out_valid`=0, `in_ready`=1.
